// File: rtl/lsu_bus_sequencer_if.sv
// Valid/ready data-memory bus between the load/store sequencer (master) and memory (slave).
interface lsu_bus_sequencer_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_err;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_sequencer.sv
// Multi-cycle load/store sequencer: decoder memory controls -> valid/ready bus, stalls until done.
// Optional bus wait timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [2:0]  mem_acc_mode_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        misalign_ld_o,
  output logic        misalign_st_o,
  lsu_bus_sequencer_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be in 1 .. 2**CNT_W-1");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state_q;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q, load_data_q;
  logic [3:0]  bus_be_q;
  logic [2:0]  mode_q;
  logic [1:0]  off_q;

  logic        vld_ld, vld_st, is_half, is_word, mis, go, timeout_take;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_fmt_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign vld_ld  = rd_en_i & ~wr_en_i & (mem_acc_mode_i <= 3'b100);
  assign vld_st  = wr_en_i & ~rd_en_i & (mem_acc_mode_i <= 3'b010);
  assign is_half = (mem_acc_mode_i == 3'b001) | (mem_acc_mode_i == 3'b100);
  assign is_word = (mem_acc_mode_i == 3'b010);
  assign mis     = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));

  assign misalign_ld_o = (state_q == IDLE) & vld_ld & mis;
  assign misalign_st_o = (state_q == IDLE) & vld_st & mis;
  assign go            = (state_q == IDLE) & (vld_ld | vld_st) & ~mis;
  assign stall_o       = go | (state_q == REQ) | (state_q == WAIT_R);

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    case (mem_acc_mode_i)
      3'b000, 3'b011: be_d = 4'b0001 << addr_i[1:0];
      3'b001, 3'b100: be_d = 4'b0011 << addr_i[1:0];
      default:        be_d = 4'b1111;
    endcase
    case (mem_acc_mode_i)
      3'b000:  wdata_d = {4{wdata_i[7:0]}};
      3'b001:  wdata_d = {2{wdata_i[15:0]}};
      default: wdata_d = wdata_i;
    endcase
  end

  // Lane selection uses the offset captured at issue, not the live address.
  always_comb begin
    lane_b = bus.bus_rdata[7:0];
    case (off_q)
      2'd1:    lane_b = bus.bus_rdata[15:8];
      2'd2:    lane_b = bus.bus_rdata[23:16];
      2'd3:    lane_b = bus.bus_rdata[31:24];
      default: lane_b = bus.bus_rdata[7:0];
    endcase
    lane_h = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (mode_q)
      3'b000:  ld_fmt_d = {{24{lane_b[7]}}, lane_b};
      3'b011:  ld_fmt_d = {24'h0, lane_b};
      3'b001:  ld_fmt_d = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_fmt_d = {16'h0, lane_h};
      default: ld_fmt_d = bus.bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // A handshake in the same cycle as expiry wins over the timeout.
  assign timeout_take = (cnt_q == CNT_LAST) &
                        (((state_q == REQ) & ~bus.bus_gnt) | ((state_q == WAIT_R) & ~bus.bus_rvalid));
  assign bus.bus_err  = bus_err_q;
`else
  assign timeout_take = 1'b0;
  assign bus.bus_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      load_data_q <= '0;
      mode_q      <= 3'b111;
      off_q       <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (go) begin
          bus_req_q   <= 1'b1;
          bus_we_q    <= vld_st;
          bus_addr_q  <= {addr_i[31:2], 2'b00};
          bus_be_q    <= be_d;
          bus_wdata_q <= wdata_d;
          mode_q      <= mem_acc_mode_i;
          off_q       <= addr_i[1:0];
          state_q     <= REQ;
        end
        REQ: if (bus.bus_gnt) begin
          bus_req_q <= 1'b0;
          state_q   <= bus_we_q ? DONE : WAIT_R;
        end else if (timeout_take) begin
          bus_req_q <= 1'b0;
          state_q   <= DONE;
          if (!bus_we_q) load_data_q <= '0;
        end
        WAIT_R: if (bus.bus_rvalid) begin
          load_data_q <= ld_fmt_d;
          state_q     <= DONE;
        end else if (timeout_take) begin
          load_data_q <= '0;
          state_q     <= DONE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= ((state_q == REQ) || (state_q == WAIT_R)) ? cnt_q + 1'b1 : '0;
      bus_err_q <= timeout_take;
`endif
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign load_data_o   = load_data_q;

endmodule

// File: tb/tb_lsu_bus_sequencer.sv
// Scoreboard bench for lsu_bus_sequencer: stimulus pushes expectations, a negedge monitor checks them.
module tb_lsu_bus_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, rd_en, wr_en;
  logic [2:0]  mode;
  logic [31:0] addr, wdata, load_data;
  logic        stall, mis_ld, mis_st;

  always #5 clk = ~clk;

  lsu_bus_sequencer_if bus_if ();

  lsu_bus_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en_i(rd_en), .wr_en_i(wr_en),
    .mem_acc_mode_i(mode), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall), .load_data_o(load_data),
    .misalign_ld_o(mis_ld), .misalign_st_o(mis_st), .bus(bus_if.master)
  );

  typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} req_t;
  typedef struct {logic [31:0] ld; logic err; int slen;} cmp_t;
  typedef struct {logic ld; logic st;} flg_t;

  req_t req_q[$];
  cmp_t cmp_q[$];
  flg_t flg_q[$];
  int checks = 0, errors = 0;
  logic [31:0] last_ld = 32'h0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor
  req_t cur;
  cmp_t ce;
  flg_t fe;
  logic prev_req = 1'b0, prev_stall = 1'b0;
  int   srun = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_req = 1'b0; prev_stall = 1'b0; srun = 0;
      end else begin
        if (bus_if.bus_req) begin
          if (!prev_req) begin
            if (req_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_req: bus_req=1 addr %h, expected no request", bus_if.bus_addr);
              cur = '{bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata};
            end else begin
              cur = req_q.pop_front();
              check("req_we", 32'(bus_if.bus_we), 32'(cur.we));
              check("req_addr", bus_if.bus_addr, cur.addr);
              check("req_be", 32'(bus_if.bus_be), 32'(cur.be));
              if (cur.we) check("req_wdata", bus_if.bus_wdata, cur.wdata);
            end
          end else begin
            check("hold_addr", bus_if.bus_addr, cur.addr);
            check("hold_be", 32'(bus_if.bus_be), 32'(cur.be));
            if (cur.we) check("hold_wdata", bus_if.bus_wdata, cur.wdata);
          end
        end
        prev_req = bus_if.bus_req;

        if (mis_ld || mis_st) begin
          if (flg_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_flag: ld=%b st=%b, expected none", mis_ld, mis_st);
          end else begin
            fe = flg_q.pop_front();
            check("mis_ld", 32'(mis_ld), 32'(fe.ld));
            check("mis_st", 32'(mis_st), 32'(fe.st));
          end
        end

        if (prev_stall && !stall) begin
          if (cmp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: stall fell, expected no completion");
          end else begin
            ce = cmp_q.pop_front();
            check("load_data", load_data, ce.ld);
            check("bus_err", 32'(bus_if.bus_err), 32'(ce.err));
            check("stall_len", 32'(srun), 32'(ce.slen));
          end
        end else if (bus_if.bus_err) begin
          checks++; errors++;
          $display("FAIL stray_bus_err: bus_err=1 outside completion, expected 0");
        end
        srun = stall ? srun + 1 : 0;
        prev_stall = stall;
      end
    end
  end

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] m,
                            input logic [31:0] a, input logic [31:0] w,
                            input int gd, input int rvd, input logic [31:0] rdat);
    bit granted = 0, done = 0;
    int gc = 0, wc = 0;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; mode = m; addr = a; wdata = w;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk); #1;
      if (!stall) begin
        rd_en = 1'b0; wr_en = 1'b0; mode = 3'b111;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
        done = 1;
      end else if (bus_if.bus_req) begin
        bus_if.bus_gnt = (gc == gd); gc++;
        if (bus_if.bus_gnt) granted = 1;
        bus_if.bus_rvalid = 1'b0;
      end else if (granted) begin
        bus_if.bus_gnt = 1'b0;
        bus_if.bus_rvalid = (wc == rvd); bus_if.bus_rdata = rdat; wc++;
      end else begin
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout: stall still %b after 200 cycles, expected completion", stall);
      rd_en = 1'b0; wr_en = 1'b0; bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
    end
  endtask

  task automatic do_ld(input logic [2:0] m, input logic [31:0] a, input logic [31:0] rdat,
                       input int gd, input int rvd, input logic [3:0] be,
                       input logic [31:0] exp_ld, input int slen);
    req_q.push_back('{1'b0, a & 32'hFFFF_FFFC, be, 32'h0});
    cmp_q.push_back('{exp_ld, 1'b0, slen});
    last_ld = exp_ld;
    run_access(1'b1, 1'b0, m, a, 32'h0, gd, rvd, rdat);
  endtask

  task automatic do_st(input logic [2:0] m, input logic [31:0] a, input logic [31:0] w,
                       input int gd, input logic [3:0] be, input logic [31:0] exp_wd, input int slen);
    req_q.push_back('{1'b1, a & 32'hFFFF_FFFC, be, exp_wd});
    cmp_q.push_back('{last_ld, 1'b0, slen});
    run_access(1'b0, 1'b1, m, a, w, gd, 0, 32'h0);
  endtask

  task automatic do_nobus(input logic rd, input logic wr, input logic [2:0] m, input logic [31:0] a,
                          input logic eld, input logic est);
    if (eld || est) flg_q.push_back('{eld, est});
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; mode = m; addr = a; wdata = 32'h5555_AAAA;
    @(negedge clk); #1;
    check("nobus_stall", 32'(stall), 32'h0);
    rd_en = 1'b0; wr_en = 1'b0; mode = 3'b111;
    @(negedge clk); #1;
    check("nobus_req", 32'(bus_if.bus_req), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; mode = 3'b111; addr = '0; wdata = '0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(bus_if.bus_req), 32'h0);
    check("rst_we", 32'(bus_if.bus_we), 32'h0);
    check("rst_addr", bus_if.bus_addr, 32'h0);
    check("rst_be", 32'(bus_if.bus_be), 32'h0);
    check("rst_wdata", bus_if.bus_wdata, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_bus_err", 32'(bus_if.bus_err), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    //      mode    addr          rdata          gd rv be       expected     stall
    do_ld(3'b000, 32'h0000_0103, 32'h80FF_1234, 0, 0, 4'b1000, 32'hFFFF_FF80, 3);
    do_st(3'b001, 32'h0000_0202, 32'h0000_ABCD, 4,    4'b1100, 32'hABCD_ABCD, 6);
    do_ld(3'b100, 32'h0000_0002, 32'h8001_0000, 0, 2, 4'b1100, 32'h0000_8001, 5);
    do_ld(3'b001, 32'h0000_0002, 32'h8001_0000, 0, 0, 4'b1100, 32'hFFFF_8001, 3);
    do_ld(3'b000, 32'h0000_0001, 32'h0000_7F00, 1, 0, 4'b0010, 32'h0000_007F, 4);
    do_ld(3'b011, 32'h0000_0003, 32'hAB00_0000, 0, 0, 4'b1000, 32'h0000_00AB, 3);
    do_st(3'b000, 32'h0000_0001, 32'h1234_56EF, 1,    4'b0010, 32'hEFEF_EFEF, 3);
    do_st(3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0,    4'b1111, 32'hDEAD_BEEF, 2);
    do_ld(3'b010, 32'h0000_0024, 32'hCAFE_F00D, 2, 1, 4'b1111, 32'hCAFE_F00D, 6);

    do_nobus(1'b1, 1'b0, 3'b010, 32'h0000_0006, 1'b1, 1'b0);
    do_nobus(1'b0, 1'b1, 3'b010, 32'h0000_0005, 1'b0, 1'b1);
    do_nobus(1'b0, 1'b1, 3'b100, 32'h0000_0003, 1'b1 & 1'b0, 1'b0);
    do_nobus(1'b1, 1'b1, 3'b010, 32'h0000_0000, 1'b0, 1'b0);
    do_nobus(1'b1, 1'b0, 3'b111, 32'h0000_0000, 1'b0, 1'b0);
    do_nobus(1'b0, 1'b1, 3'b011, 32'h0000_0000, 1'b0, 1'b0);

    // Reset while waiting for read data abandons the load.
    req_q.push_back('{1'b0, 32'h0000_0040, 4'b1111, 32'h0});
    @(posedge clk); #1;
    rd_en = 1'b1; wr_en = 1'b0; mode = 3'b010; addr = 32'h0000_0040;
    @(posedge clk); #1 bus_if.bus_gnt = 1'b1;
    @(posedge clk); #1 bus_if.bus_gnt = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; rd_en = 1'b0; mode = 3'b111;
    @(negedge clk); #1;
    check("rstw_req", 32'(bus_if.bus_req), 32'h0);
    check("rstw_load_data", load_data, 32'h0);
    check("rstw_stall", 32'(stall), 32'h0);
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    @(posedge clk); #1 bus_if.bus_rvalid = 1'b0;
    @(negedge clk); #1;
    check("late_rvalid_load_data", load_data, 32'h0);
    check("late_rvalid_stall", 32'(stall), 32'h0);
    last_ld = 32'h0;

`ifdef LSU_TIMEOUT_EN
    req_q.push_back('{1'b0, 32'h0000_0000, 4'b0001, 32'h0});
    cmp_q.push_back('{32'h0, 1'b1, 9});
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0, 1000, 0, 32'h0);
    last_ld = 32'h0;
`else
    do_st(3'b010, 32'h0000_0030, 32'h1122_3344, 20, 4'b1111, 32'h1122_3344, 22);
`endif
    do_ld(3'b000, 32'h0000_0100, 32'h0000_0042, 0, 0, 4'b0001, 32'h0000_0042, 3);

    repeat (3) @(negedge clk);
    check("req_queue_empty", 32'(req_q.size()), 32'h0);
    check("cmp_queue_empty", 32'(cmp_q.size()), 32'h0);
    check("flag_queue_empty", 32'(flg_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_bus_sequencer.md
Name: lsu_bus_sequencer

Overview:
- Multi-cycle load/store sequencer between the decoder's memory controls and a valid/ready data-memory bus.
- Decoder controls used: rd_en, wr_en, mem_acc_mode.
- Per access it:
  - builds the word-aligned bus request, byte enables and lane-replicated write data;
  - stalls the pipeline until the bus completes;
  - returns sign/zero-extended load data to the writeback mux.
- Misaligned accesses are detected and reported without touching the bus.

Parameters:
- TIMEOUT_CYCLES, 255: bus wait limit, in cycles. Used only with LSU_TIMEOUT_EN.
- CNT_W, 8: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rd_en  in  1  load request from decoder
- wr_en  in  1  store request from decoder
- mem_acc_mode  in  3  000 B, 001 H, 010 W, 011 BU, 100 HU, 111 none
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC and pipeline registers
- load_data  out  32  extended load result to writeback
- misalign_ld  out  1  misaligned load flag
- misalign_st  out  1  misaligned store flag
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted (ready)
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data
- bus_err  out  1  timeout flag; tied 0 without the macro

Behaviour:
- Reset:
  - rst_n=0 at a clk edge forces state IDLE.
  - All registered outputs clear: bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data, bus_err, timeout counter.
  - Reset mid-transaction abandons the access with no completion.
- Access validity:
  - Valid load: rd_en=1, wr_en=0, mode in {000,001,010,011,100}.
  - Valid store: wr_en=1, rd_en=0, mode in {000,001,010}.
  - Anything else, including rd_en=wr_en=1: no bus activity, stall=0, no flags.
- Misalignment:
  - H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Combinationally in IDLE: misalign_ld or misalign_st = 1, stall=0, no bus access.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: 4'b0011<<addr[1:0].
  - W: 4'b1111.
- Write data: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata.
- FSM states: IDLE, REQ, WAIT_R, DONE.
  - IDLE: on a valid aligned access, register bus_addr, bus_be, bus_we and bus_wdata; set bus_req=1; go to REQ. stall=1 combinationally in that same cycle.
  - REQ: bus_req held with stable fields until bus_gnt=1.
    - Store: on bus_gnt, bus_req drops and the FSM goes to DONE.
    - Load: on bus_gnt, bus_req drops and the FSM goes to WAIT_R.
    - stall=1.
  - WAIT_R: stall=1. bus_rvalid is only honoured from the cycle after gnt. On bus_rvalid, capture the extended lane into load_data and go to DONE.
  - DONE: stall=0 for exactly one cycle; the pipeline advances; next state is IDLE. The request still on the inputs in DONE is never re-issued.
- Load formatting: lane = bus_rdata byte/half at addr[1:0] (H uses addr[1]).
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
  - load_data holds its value until the next load completes.
- Minimum latency:
  - Store: 3 cycles (IDLE, REQ with gnt, DONE).
  - Load: 4 cycles (IDLE, REQ with gnt, WAIT_R with rvalid, DONE).

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - The counter increments every cycle spent in REQ or WAIT_R and clears on entry to IDLE.
  - When the counter reaches TIMEOUT_CYCLES: bus_req=0, go to DONE, bus_err=1 for the DONE cycle, load_data=0 for a load.
  - A bus_gnt or bus_rvalid arriving in the same cycle as the timeout takes priority; no error is flagged.
- Not defined: no counter; the FSM waits indefinitely; bus_err is constant 0.

Test Plan:
- LB at addr 0x103, bus_rdata 0x80FF_1234, gnt and rvalid each after 1 cycle -> be=4'b1000, bus_addr 0x100, load_data 0xFFFF_FF80, stall high for exactly 3 cycles.
- SH at addr 0x202, wdata 0x0000_ABCD, gnt delayed 4 cycles -> bus_req/be=4'b1100/bus_wdata 0xABCD_ABCD stable until gnt, then DONE, stall low 1 cycle.
- LHU at 0x2, rdata 0x8001_0000 -> load_data 0x0000_8001. LW at 0x6 -> misalign_ld=1, bus_req never asserts, stall=0.
- rst_n low in WAIT_R -> next cycle IDLE, bus_req=0, load_data=0. A late bus_rvalid is ignored.
- rd_en=wr_en=1, or mode 111 -> no bus_req, stall=0, no flags.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, bus_gnt never asserts -> bus_err pulses 1 cycle after 8 cycles in REQ, load_data=0, FSM returns to IDLE.
